pwm_duty_meter: RTL

//  Receive side of the PWM link: samples an external PWM waveform (as produced by
//  the team's 10%-step PWM generator) and measures its period and high time in clk

---
 rtl/pwm_duty_meter.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures period and high time of an asynchronous PWM input
// in clk cycles and converts the measurement to a 0..10 duty step (10% units).
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-high reset
//   pwm_in     - asynchronous PWM input (synchronized internally)
//   period_cnt - last measured period in clk cycles
//   high_cnt   - last measured high time in clk cycles
//   duty_step  - floor(10*high_cnt/period_cnt), clamped to 0..10
//   valid      - one-cycle pulse when period_cnt/high_cnt/duty_step update
//   stuck      - no input edge seen for TIMEOUT cycles
//   overflow   - sticky: a period exceeded the counter range
module pwm_duty_meter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [3:0]       duty_step,
  output logic             valid,
  output logic             stuck,
  output logic             overflow
);

  localparam int unsigned ACC_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [3:0]       STEP_MAX  = 4'd10;

  typedef enum logic {M_IDLE, M_MEASURE} mstate_t;
  typedef enum logic [1:0] {D_IDLE, D_CALC, D_DONE} dstate_t;

  // Synchronizer and edge detect
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s_dly_q, s_dly_d;
  logic s_c, rise_c, fall_c;

  // Measurement
  mstate_t          mstate_q, mstate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic             snap_c;

  // Timeout
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             timeout_c;

  // Divider and pending snapshot
  dstate_t          dstate_q, dstate_d;
  logic [CNT_W-1:0] div_period_q, div_period_d;
  logic [CNT_W-1:0] div_high_q, div_high_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       quo_q, quo_d;
  logic             pend_vld_q, pend_vld_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             ld_c;
  logic [CNT_W-1:0] ld_period_c, ld_high_c;

  // Output registers
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [3:0]       duty_step_q, duty_step_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             overflow_q, overflow_d;

  // Input synchronizer, edge detection, idle timeout and stuck flag
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    s_c     = sync2_q;
    s_dly_d = s_c;
    rise_c  = s_c & ~s_dly_q;
    fall_c  = ~s_c & s_dly_q;

    // Only one timeout per stuck episode: gated by stuck_q until the next rise.
    timeout_c = !stuck_q && !rise_c && !fall_c && (idle_q == (TIMEOUT_V - CNT_ONE));

    idle_d = idle_q;
    if (rise_c || fall_c) begin
      idle_d = '0;
    end else if (idle_q != TIMEOUT_V) begin
      idle_d = idle_q + CNT_ONE;
    end

    stuck_d = stuck_q;
    if (timeout_c) begin
      stuck_d = 1'b1;
    end else if (rise_c) begin
      stuck_d = 1'b0;
    end
  end

  // Measure FSM: period counter, high-time capture, snapshot/overflow on rise
  always_comb begin
    mstate_d   = mstate_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    snap_c     = 1'b0;
    overflow_d = overflow_q;

    case (mstate_q)
      M_IDLE: begin
        if (rise_c) begin
          mstate_d = M_MEASURE;
          cnt_d    = CNT_ONE;
        end
      end
      M_MEASURE: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
        if (fall_c) begin
          hi_d = cnt_q;
        end
        if (rise_c) begin
          // A saturated counter means the period is out of range.
          if (cnt_q != CNT_MAX) begin
            snap_c = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          cnt_d = CNT_ONE;
        end
      end
      default: mstate_d = M_IDLE;
    endcase

    if (timeout_c) begin
      mstate_d = M_IDLE;
    end
  end

  // Divider FSM (repeated subtraction), pending snapshot slot and output update
  always_comb begin
    dstate_d      = dstate_q;
    div_period_d  = div_period_q;
    div_high_d    = div_high_q;
    acc_d         = acc_q;
    quo_d         = quo_q;
    pend_vld_d    = pend_vld_q;
    pend_period_d = pend_period_q;
    pend_high_d   = pend_high_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    duty_step_d   = duty_step_q;
    valid_d       = 1'b0;
    ld_c          = 1'b0;
    ld_period_c   = cnt_q;
    ld_high_c     = hi_q;

    case (dstate_q)
      D_IDLE: begin
        if (snap_c) begin
          ld_c = 1'b1;
        end
      end
      D_CALC: begin
        // Newest snapshot overwrites any older pending one.
        if (snap_c) begin
          pend_vld_d    = 1'b1;
          pend_period_d = cnt_q;
          pend_high_d   = hi_q;
        end
        if ((acc_q >= ACC_W'(div_period_q)) && (quo_q < STEP_MAX)) begin
          acc_d = acc_q - ACC_W'(div_period_q);
          quo_d = quo_q + 4'd1;
        end else begin
          dstate_d = D_DONE;
        end
      end
      D_DONE: begin
        period_cnt_d = div_period_q;
        high_cnt_d   = div_high_q;
        duty_step_d  = quo_q;
        valid_d      = 1'b1;
        dstate_d     = D_IDLE;
        pend_vld_d   = 1'b0;
        // Restart directly from here: a same-cycle snapshot is newer than pending.
        if (snap_c) begin
          ld_c = 1'b1;
        end else if (pend_vld_q) begin
          ld_c        = 1'b1;
          ld_period_c = pend_period_q;
          ld_high_c   = pend_high_q;
        end
      end
      default: dstate_d = D_IDLE;
    endcase

    if (ld_c) begin
      dstate_d     = D_CALC;
      div_period_d = ld_period_c;
      div_high_d   = ld_high_c;
      acc_d        = (ACC_W'(ld_high_c) << 3) + (ACC_W'(ld_high_c) << 1);
      quo_d        = 4'd0;
    end

    // Timeout overrides any divider result and abandons queued work.
    if (timeout_c) begin
      dstate_d     = D_IDLE;
      pend_vld_d   = 1'b0;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      duty_step_d  = s_c ? STEP_MAX : 4'd0;
      valid_d      = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      s_dly_q       <= 1'b0;
      mstate_q      <= M_IDLE;
      cnt_q         <= '0;
      hi_q          <= '0;
      idle_q        <= '0;
      dstate_q      <= D_IDLE;
      div_period_q  <= '0;
      div_high_q    <= '0;
      acc_q         <= '0;
      quo_q         <= '0;
      pend_vld_q    <= 1'b0;
      pend_period_q <= '0;
      pend_high_q   <= '0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      duty_step_q   <= '0;
      valid_q       <= 1'b0;
      stuck_q       <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      s_dly_q       <= s_dly_d;
      mstate_q      <= mstate_d;
      cnt_q         <= cnt_d;
      hi_q          <= hi_d;
      idle_q        <= idle_d;
      dstate_q      <= dstate_d;
      div_period_q  <= div_period_d;
      div_high_q    <= div_high_d;
      acc_q         <= acc_d;
      quo_q         <= quo_d;
      pend_vld_q    <= pend_vld_d;
      pend_period_q <= pend_period_d;
      pend_high_q   <= pend_high_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      duty_step_q   <= duty_step_d;
      valid_q       <= valid_d;
      stuck_q       <= stuck_d;
      overflow_q    <= overflow_d;
    end
  end

  assign period_cnt = period_cnt_q;
  assign high_cnt   = high_cnt_q;
  assign duty_step  = duty_step_q;
  assign valid      = valid_q;
  assign stuck      = stuck_q;
  assign overflow   = overflow_q;

endmodule
